// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: on-chip circular record of CPU fetch events with arm/trigger windowing.
// Optional TRACE_MEMWR_EN adds a store-event port whose records carry kind=1.
module cpu_trace_buffer #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 64,
   parameter int STATE_W   = 4,
   parameter int CYC_W     = 16,
   parameter int POST_TRIG = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int EW = 1 + CYC_W + STATE_W + 2*DATA_W
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               arm,
   input  logic               trigger,
   input  logic               mode_wrap,
   input  logic               fetch_valid,
   input  logic [DATA_W-1:0]  pc,
   input  logic [DATA_W-1:0]  ir,
   input  logic [STATE_W-1:0] cpu_state,
`ifdef TRACE_MEMWR_EN
   input  logic               mem_we,
   input  logic [DATA_W-1:0]  mem_addr,
   input  logic [DATA_W-1:0]  mem_wdata,
`endif
   input  logic [AW-1:0]      rd_addr,
   output logic [EW-1:0]      rd_data,
   output logic [AW:0]        count,
   output logic               capturing,
   output logic               done,
   output logic               overflow
);

   // state  | meaning
   // S_IDLE | waiting for arm, nothing recorded
   // S_PRE  | capturing, waiting for trigger
   // S_POST | capturing, counting down post-trigger window
   // S_DONE | frozen; only arm restarts
   typedef enum logic [1:0] {S_IDLE, S_PRE, S_POST, S_DONE} state_t;

   localparam int PW = (POST_TRIG < 1) ? 1 : $clog2(POST_TRIG + 1);

   state_t             state;
   logic [EW-1:0]      mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_phys;
   logic [CYC_W-1:0]   cycle;
   logic [PW-1:0]      post_cnt;
   logic               cap_req;
   logic               kind;
   logic               store_lost;
   logic               active;
   logic               full;
   logic               wr_en;
   logic               drop;
   logic [DATA_W-1:0]  fld_a;
   logic [DATA_W-1:0]  fld_b;
   logic [EW-1:0]      entry;

   // Fetch wins over a simultaneous store; the store is lost and flagged.
   always_comb begin
`ifdef TRACE_MEMWR_EN
      cap_req    = fetch_valid | mem_we;
      kind       = ~fetch_valid & mem_we;
      store_lost = fetch_valid & mem_we;
      fld_a      = fetch_valid ? pc : mem_addr;
      fld_b      = fetch_valid ? ir : mem_wdata;
`else
      cap_req    = fetch_valid;
      kind       = 1'b0;
      store_lost = 1'b0;
      fld_a      = pc;
      fld_b      = ir;
`endif
      active  = (state == S_PRE) || (state == S_POST);
      full    = (count == (AW+1)'(DEPTH));
      wr_en   = active & ~arm & cap_req & (~full | mode_wrap);
      drop    = active & ~arm & cap_req & full & ~mode_wrap;
      entry   = {kind, cycle, cpu_state, fld_a, fld_b};
      rd_phys = wr_ptr - count[AW-1:0] + rd_addr;
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cycle <= '0;
      else if (cycle != {CYC_W{1'b1}})
         cycle <= cycle + CYC_W'(1);
   end

   // Read sees pre-edge memory, so a same-slot write returns the old entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rd_data <= '0;
      else if ({1'b0, rd_addr} < count)
         rd_data <= mem[rd_phys];
      else
         rd_data <= '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         count     <= '0;
         post_cnt  <= '0;
         overflow  <= 1'b0;
         capturing <= 1'b0;
         done      <= 1'b0;
      end else if (arm) begin
         state     <= S_PRE;
         wr_ptr    <= '0;
         count     <= '0;
         post_cnt  <= '0;
         overflow  <= 1'b0;
         capturing <= 1'b1;
         done      <= 1'b0;
      end else if (active) begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (full)
               overflow <= 1'b1;
            else
               count <= count + (AW+1)'(1);
         end
         if (store_lost)
            overflow <= 1'b1;
         if (drop) begin
            overflow  <= 1'b1;
            state     <= S_DONE;
            capturing <= 1'b0;
            done      <= 1'b1;
         end else if (state == S_PRE && trigger) begin
            // A capture in the trigger cycle is the first post-trigger entry.
            if (POST_TRIG == 0 || (POST_TRIG == 1 && wr_en)) begin
               state     <= S_DONE;
               capturing <= 1'b0;
               done      <= 1'b1;
            end else begin
               post_cnt <= PW'(POST_TRIG) - PW'(wr_en);
               state    <= S_POST;
            end
         end else if (state == S_POST && wr_en) begin
            post_cnt <= post_cnt - PW'(1);
            if (post_cnt == PW'(1)) begin
               state     <= S_DONE;
               capturing <= 1'b0;
               done      <= 1'b1;
            end
         end
      end
   end

endmodule
